// File: rtl/fft_frame_ctrl_if.sv
// fft_frame_ctrl_if: source stream, FFT core, result sink and status signals around fft_frame_ctrl
interface fft_frame_ctrl_if #(
   parameter int DW = 64
);
   logic          s_vld, s_rdy, s_last;
   logic [DW-1:0] s_d0, s_d1;
   logic          fft_start, fft_done;
   logic [DW-1:0] fft_d0, fft_d1, fft_q0, fft_q1;
   logic          m_vld, m_last;
   logic [DW-1:0] m_q0, m_q1;
   logic          busy, err_clr;
   logic [2:0]    err;
   logic [15:0]   frames;
   modport master (
      output s_vld, s_d0, s_d1, s_last, fft_done, fft_q0, fft_q1, err_clr,
      input  s_rdy, fft_start, fft_d0, fft_d1, m_vld, m_q0, m_q1, m_last, busy, err, frames
   );
   modport slave (
      input  s_vld, s_d0, s_d1, s_last, fft_done, fft_q0, fft_q1, err_clr,
      output s_rdy, fft_start, fft_d0, fft_d1, m_vld, m_q0, m_q1, m_last, busy, err, frames
   );
endinterface

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: buffers one frame, kicks and feeds the FFT core, then forwards and checks its result window
module fft_frame_ctrl #(
   parameter int DW  = 64,
   parameter int NPT = 64,
   parameter int TMO = 4096
) (
   input  logic            i_clk,
   input  logic            i_rst,
   fft_frame_ctrl_if.slave io_bus
);
   localparam int BEATS = NPT / 2;
   localparam int AW    = $clog2(BEATS);
   localparam int CW    = $clog2(BEATS + 2);
   localparam int TW    = $clog2(TMO + 1);
   typedef enum logic [2:0] {IDLE, KICK, LOAD, WAIT, DRAIN} state_t;
   state_t          r_state, w_state_nx;
   logic [2*DW-1:0] r_buf [BEATS];
   logic [CW-1:0]   r_wr_cnt, r_out_cnt;
   logic [AW-1:0]   r_rd_cnt;
   logic [TW-1:0]   r_tmo;
   logic [DW-1:0]   r_m_q0, r_m_q1;
   logic            r_m_vld, r_m_last;
   logic [2:0]      r_err, w_err_set;
   logic [15:0]     r_frames;
   logic            w_full, w_xfer, w_full_nx, w_load_end, w_win, w_cap, w_fall, w_good, w_tmo_hit;
   assign w_full     = r_wr_cnt == CW'(BEATS);
   assign w_xfer     = io_bus.s_vld && io_bus.s_rdy;
   assign w_full_nx  = w_full || (w_xfer && r_wr_cnt == CW'(BEATS - 1));
   assign w_load_end = r_state == LOAD && r_rd_cnt == AW'(BEATS - 1);
   assign w_win      = (r_state == WAIT || r_state == DRAIN) && io_bus.fft_done;
   assign w_cap      = w_win && r_out_cnt < CW'(BEATS);
   assign w_fall     = r_state == DRAIN && !io_bus.fft_done;
   assign w_good     = w_fall && r_out_cnt == CW'(BEATS);
   assign w_tmo_hit  = r_state == WAIT && !io_bus.fft_done && r_tmo == TW'(TMO - 1);
   assign w_err_set  = {w_xfer && (io_bus.s_last != (r_wr_cnt == CW'(BEATS - 1))), w_fall && !w_good, w_tmo_hit};
   assign io_bus.s_rdy     = !w_full && (r_state == IDLE || r_state == WAIT || r_state == DRAIN);
   assign io_bus.fft_start = r_state == KICK;
   assign io_bus.fft_d0    = r_state == LOAD ? r_buf[r_rd_cnt][2*DW-1:DW] : '0;
   assign io_bus.fft_d1    = r_state == LOAD ? r_buf[r_rd_cnt][DW-1:0] : '0;
   assign io_bus.m_vld     = r_m_vld;
   assign io_bus.m_last    = r_m_last;
   assign io_bus.m_q0      = r_m_q0;
   assign io_bus.m_q1      = r_m_q1;
   assign io_bus.busy      = r_state != IDLE;
   assign io_bus.err       = r_err;
   assign io_bus.frames    = r_frames;
   // state register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else r_state <= w_state_nx;
   end
   // next state: a full buffer (including the beat landing now) launches the next frame
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE:    w_state_nx = w_full_nx ? KICK : IDLE;
         KICK:    w_state_nx = LOAD;
         LOAD:    w_state_nx = w_load_end ? WAIT : LOAD;
         WAIT:    w_state_nx = io_bus.fft_done ? DRAIN : (w_tmo_hit ? IDLE : WAIT);
         DRAIN:   w_state_nx = w_fall ? (w_full_nx ? KICK : IDLE) : DRAIN;
         default: w_state_nx = IDLE;
      endcase
   end
   // frame buffer, contents are don't-care after reset
   always_ff @(posedge i_clk) begin
      if (w_xfer) r_buf[r_wr_cnt[AW-1:0]] <= {io_bus.s_d0, io_bus.s_d1};
   end
   // counters, result register, sticky errors and good-frame count
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_cnt  <= '0;
         r_rd_cnt  <= '0;
         r_tmo     <= '0;
         r_out_cnt <= '0;
         r_m_vld   <= 1'b0;
         r_m_last  <= 1'b0;
         r_m_q0    <= '0;
         r_m_q1    <= '0;
         r_err     <= '0;
         r_frames  <= '0;
      end else begin
         r_wr_cnt  <= w_load_end ? '0 : (w_xfer ? r_wr_cnt + CW'(1) : r_wr_cnt);
         r_rd_cnt  <= r_state == LOAD ? r_rd_cnt + AW'(1) : '0;
         r_tmo     <= r_state == WAIT ? r_tmo + TW'(1) : '0;
         r_out_cnt <= r_state == KICK ? '0 : ((w_win && r_out_cnt != CW'(BEATS + 1)) ? r_out_cnt + CW'(1) : r_out_cnt);
         r_m_vld   <= w_cap;
         r_m_last  <= w_cap && r_out_cnt == CW'(BEATS - 1);
         r_m_q0    <= w_cap ? io_bus.fft_q0 : r_m_q0;
         r_m_q1    <= w_cap ? io_bus.fft_q1 : r_m_q1;
         r_err     <= io_bus.err_clr ? '0 : (r_err | w_err_set);
         r_frames  <= w_good ? r_frames + 16'd1 : r_frames;
      end
   end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed frame scenarios with random samples against a frame-level reference model
module tb_fft_frame_ctrl;
   localparam logic [63:0] K = 64'hA5A5_5A5A_0F0F_F0F0;
   logic clk = 1'b0, rst = 1'b1;
   int checks = 0, failures = 0, cyc = 0, rdy_viol = 0, load_end_cyc = 0;
   int core_lat = 0, core_win = 32, idle_cyc = 0;
   logic [128:0] m_q[$], exp_m[$];
   logic [127:0] ld_q[$], exp_ld[$], cur[32];
   int start_cyc[$], last_cyc[$];
   fft_frame_ctrl_if #(.DW(64)) bus ();
   fft_frame_ctrl #(.DW(64), .NPT(64), .TMO(16)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus.slave));
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (bus.m_vld) begin
         m_q.push_back({bus.m_last, bus.m_q0, bus.m_q1});
         if (bus.m_last) last_cyc.push_back(cyc);
      end
      if (bus.fft_start) start_cyc.push_back(cyc);
   end
   // core model: captures the 32 loaded beats, then after core_lat cycles holds DONE for core_win cycles
   initial begin
      bus.fft_done = 1'b0;
      bus.fft_q0 = '0;
      bus.fft_q1 = '0;
      forever begin
         @(negedge clk);
         if (bus.fft_start) begin
            if (bus.s_rdy) rdy_viol++;
            for (int j = 0; j < 32; j++) begin
               @(negedge clk);
               if (bus.s_rdy) rdy_viol++;
               cur[j] = {bus.fft_d0, bus.fft_d1};
               ld_q.push_back(cur[j]);
            end
            load_end_cyc = cyc;
            if (core_win > 0) repeat (core_lat) @(negedge clk);
            for (int j = 0; j < core_win; j++) begin
               bus.fft_done = 1'b1;
               bus.fft_q0 = cur[j % 32][127:64] ^ K;
               bus.fft_q1 = cur[j % 32][63:0] + 64'(j);
               @(negedge clk);
            end
            bus.fft_done = 1'b0;
            bus.fft_q0 = '0;
            bus.fft_q1 = '0;
         end
      end
   end
   task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic send_beat(input logic [63:0] a, input logic [63:0] b, input logic last);
      int t = 0;
      bus.s_vld = 1'b1;
      bus.s_d0 = a;
      bus.s_d1 = b;
      bus.s_last = last;
      while (!bus.s_rdy && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("src_rdy", bus.s_rdy, 1);
      @(negedge clk);
      bus.s_vld = 1'b0;
      bus.s_last = 1'b0;
   endtask
   task automatic send_frame(input bit gaps, input int bad_k, input int win);
      logic [63:0] a, b;
      for (int k = 0; k < 32; k++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         exp_ld.push_back({a, b});
         if (k < win) exp_m.push_back({k == 31, a ^ K, b + 64'(k)});
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         send_beat(a, b, k == 31 || k == bad_k);
      end
   endtask
   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (bus.busy && t < 3000) begin
         @(negedge clk);
         t++;
      end
      idle_cyc = cyc;
      chk("busy_drop", bus.busy, 0);
   endtask
   task automatic cmp_streams();
      chk("m_count", m_q.size(), exp_m.size());
      for (int i = 0; i < m_q.size() && i < exp_m.size(); i++) chk("m_beat", m_q[i], exp_m[i]);
      chk("ld_count", ld_q.size(), exp_ld.size());
      for (int i = 0; i < ld_q.size() && i < exp_ld.size(); i++) chk("ld_beat", ld_q[i], exp_ld[i]);
      m_q.delete();
      exp_m.delete();
      ld_q.delete();
      exp_ld.delete();
      start_cyc.delete();
      last_cyc.delete();
   endtask
   task automatic clr_err();
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      chk("err_clr", bus.err, 0);
   endtask
   initial begin
      bus.s_vld = 1'b0;
      bus.s_d0 = '0;
      bus.s_d1 = '0;
      bus.s_last = 1'b0;
      bus.err_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_start", bus.fft_start, 0);
      chk("rst_mvld", bus.m_vld, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_frames", bus.frames, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_srdy", bus.s_rdy, 1);
      // contiguous frame
      core_lat = 3;
      core_win = 32;
      send_frame(0, -1, 32);
      chk("start_after_last", bus.fft_start, 1);
      wait_idle();
      cmp_streams();
      chk("f1_frames", bus.frames, 1);
      chk("f1_err", bus.err, 0);
      // source with gaps
      send_frame(1, -1, 32);
      chk("gap_start", bus.fft_start, 1);
      wait_idle();
      cmp_streams();
      chk("gap_frames", bus.frames, 2);
      chk("gap_err", bus.err, 0);
      chk("rdy_kick_load", rdy_viol, 0);
      // back-to-back frames
      core_lat = 4;
      send_frame(0, -1, 32);
      send_frame(0, -1, 32);
      wait_idle();
      chk("b2b_starts", start_cyc.size(), 2);
      chk("b2b_lasts", last_cyc.size(), 2);
      if (start_cyc.size() == 2 && last_cyc.size() == 2) chk("b2b_kick", start_cyc[1], last_cyc[0] + 1);
      cmp_streams();
      chk("b2b_frames", bus.frames, 4);
      chk("b2b_err", bus.err, 0);
      chk("b2b_rdy", rdy_viol, 0);
      // core never answers
      core_win = 0;
      send_frame(0, -1, 0);
      wait_idle();
      chk("tmo_len", idle_cyc - load_end_cyc, 17);
      chk("tmo_err", bus.err, 3'b001);
      cmp_streams();
      chk("tmo_frames", bus.frames, 4);
      clr_err();
      // short window
      core_lat = 2;
      core_win = 30;
      send_frame(0, -1, 30);
      wait_idle();
      cmp_streams();
      chk("short_err", bus.err, 3'b010);
      chk("short_frames", bus.frames, 4);
      clr_err();
      // long window
      core_win = 34;
      send_frame(1, -1, 34);
      wait_idle();
      cmp_streams();
      chk("long_err", bus.err, 3'b010);
      chk("long_frames", bus.frames, 4);
      clr_err();
      // misplaced S_LAST
      core_win = 32;
      send_frame(0, 5, 32);
      wait_idle();
      cmp_streams();
      chk("last_err", bus.err, 3'b100);
      chk("last_frames", bus.frames, 5);
      // reset while loading
      core_win = 0;
      send_frame(0, -1, 0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rl_busy", bus.busy, 0);
      chk("rl_start", bus.fft_start, 0);
      chk("rl_d0", bus.fft_d0, 0);
      chk("rl_mvld", bus.m_vld, 0);
      chk("rl_err", bus.err, 0);
      chk("rl_frames", bus.frames, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rl_srdy", bus.s_rdy, 1);
      chk("rl_idle", bus.busy, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
